// File: rtl/battle_sequencer.sv
// battle_sequencer: phase/round controller for the battle screen.
// Tracks HP, declares WIN/LOSE and composites phase pixel with overlay.
module battle_sequencer #(
    parameter int NUM_PHASES     = 3,
    parameter int HP_W           = 8,
    parameter int PLAYER_MAX_HP  = 20,
    parameter int ENEMY_MAX_HP   = 100,
    parameter int MAX_ROUNDS     = 0,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDX_W = $clog2(NUM_PHASES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PHASES-1:0]    finished_in,
    input  logic                     damage_in,
    input  logic                     attack_valid_in,
    input  logic [HP_W-1:0]          attack_amt_in,
    input  logic                     restart_in,
    input  logic [12*NUM_PHASES-1:0] phase_pixel_in,
    input  logic [11:0]              overlay_pixel_in,
    output logic [NUM_PHASES-1:0]    phase_onehot_out,
    output logic [IDX_W-1:0]         phase_idx_out,
    output logic                     round_rst_out,
    output logic [15:0]              round_count_out,
    output logic [HP_W-1:0]          player_hp_out,
    output logic [HP_W-1:0]          enemy_hp_out,
    output logic                     win_out,
    output logic                     lose_out,
    output logic [11:0]              pixel_out
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_PH = IDX_W'(NUM_PHASES - 1);
    localparam logic [HP_W-1:0]  P_MAX   = HP_W'(PLAYER_MAX_HP);
    localparam logic [HP_W-1:0]  E_MAX   = HP_W'(ENEMY_MAX_HP);
    localparam logic [15:0]      R_MAX   = 16'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        ST_PHASE,
        ST_ROUND_END,
        ST_WIN,
        ST_LOSE
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_phase;
    logic [NUM_PHASES-1:0]   r_fin_d1;
    logic [NUM_PHASES-1:0]   r_fin_d2;
    logic [WD_W-1:0]         r_wd;
    logic [HP_W-1:0]         r_php;
    logic [HP_W-1:0]         r_ehp;
    logic [15:0]             r_cnt;
    logic                    r_rrst;
    logic [NUM_PHASES-1:0]   r_onehot;
    logic                    r_win;
    logic                    r_lose;
    logic [11:0]             r_pixel;

    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        w_phase_nxt;
    logic [WD_W-1:0]         w_wd_nxt;
    logic [HP_W-1:0]         w_php_nxt;
    logic [HP_W-1:0]         w_ehp_nxt;
    logic [15:0]             w_cnt_nxt;
    logic                    w_rrst_nxt;
    logic [NUM_PHASES-1:0]   w_fin_edge;
    logic                    w_cur_edge;
    logic                    w_wd_exp;
    logic                    w_live;
    logic                    w_adv;
    logic [11:0]             w_sel_pix;
    logic [11:0]             w_pix_nxt;

    function automatic logic [3:0] sat4(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    // Finish edge for the active phase, watchdog expiry and pixel select.
    always_comb begin
        w_fin_edge = r_fin_d1 & ~r_fin_d2;
        w_cur_edge = 1'b0;
        w_sel_pix  = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (r_phase == IDX_W'(k)) begin
                w_cur_edge = w_fin_edge[k];
                w_sel_pix  = phase_pixel_in[12*k +: 12];
            end
        end
        w_wd_exp = (TIMEOUT_CYCLES != 0) && (r_wd == WD_LAST);
        w_live   = (r_state == ST_PHASE) || (r_state == ST_ROUND_END);
        w_adv    = (r_state == ST_PHASE) && (w_cur_edge || w_wd_exp);
    end

    // Next-state, HP and round bookkeeping; death overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_wd_nxt    = r_wd + 1'b1;
        w_php_nxt   = r_php;
        w_ehp_nxt   = r_ehp;
        w_cnt_nxt   = r_cnt;
        w_rrst_nxt  = 1'b0;

        if (w_live && damage_in && (r_php != '0)) begin
            w_php_nxt = r_php - 1'b1;
        end
        if (w_live && attack_valid_in) begin
            w_ehp_nxt = (attack_amt_in >= r_ehp) ? '0 : r_ehp - attack_amt_in;
        end

        unique case (r_state)
            ST_PHASE: begin
                if (w_adv) begin
                    w_wd_nxt = '0;
                    if (r_phase == LAST_PH) begin
                        w_state_nxt = ST_ROUND_END;
                        w_rrst_nxt  = 1'b1;
                        w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            ST_ROUND_END: begin
                w_wd_nxt    = '0;
                w_phase_nxt = '0;
                if ((MAX_ROUNDS != 0) && (r_cnt == R_MAX)) begin
                    w_state_nxt = ST_WIN;
                end else begin
                    w_state_nxt = ST_PHASE;
                end
            end
            ST_WIN, ST_LOSE: begin
                w_wd_nxt = '0;
                if (restart_in) begin
                    w_state_nxt = ST_PHASE;
                    w_phase_nxt = '0;
                    w_php_nxt   = P_MAX;
                    w_ehp_nxt   = E_MAX;
                    w_cnt_nxt   = '0;
                    w_rrst_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_PHASE;
                w_phase_nxt = '0;
            end
        endcase

        if (w_live && (w_php_nxt == '0)) begin
            w_state_nxt = ST_LOSE;
            w_rrst_nxt  = 1'b0;
            w_cnt_nxt   = r_cnt;
        end else if (w_live && (w_ehp_nxt == '0)) begin
            w_state_nxt = ST_WIN;
            w_rrst_nxt  = 1'b0;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Composite the active phase with the overlay; overlay alone otherwise.
    always_comb begin
        w_pix_nxt = overlay_pixel_in;
        if (r_state == ST_PHASE) begin
            w_pix_nxt = {sat4(w_sel_pix[11:8], overlay_pixel_in[11:8]),
                         sat4(w_sel_pix[7:4],  overlay_pixel_in[7:4]),
                         sat4(w_sel_pix[3:0],  overlay_pixel_in[3:0])};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_PHASE;
            r_phase  <= '0;
            r_fin_d1 <= '0;
            r_fin_d2 <= '0;
            r_wd     <= '0;
            r_php    <= P_MAX;
            r_ehp    <= E_MAX;
            r_cnt    <= '0;
            r_rrst   <= 1'b0;
            r_onehot <= NUM_PHASES'(1);
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
            r_pixel  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_fin_d1 <= finished_in;
            r_fin_d2 <= r_fin_d1;
            r_wd     <= w_wd_nxt;
            r_php    <= w_php_nxt;
            r_ehp    <= w_ehp_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rrst   <= w_rrst_nxt;
            r_onehot <= (w_state_nxt == ST_PHASE) ?
                        (NUM_PHASES'(1) << w_phase_nxt) : '0;
            r_win    <= (w_state_nxt == ST_WIN);
            r_lose   <= (w_state_nxt == ST_LOSE);
            r_pixel  <= w_pix_nxt;
        end
    end

    assign phase_onehot_out = r_onehot;
    assign phase_idx_out    = r_phase;
    assign round_rst_out    = r_rrst;
    assign round_count_out  = r_cnt;
    assign player_hp_out    = r_php;
    assign enemy_hp_out     = r_ehp;
    assign win_out          = r_win;
    assign lose_out         = r_lose;
    assign pixel_out        = r_pixel;

endmodule

// File: doc/battle_sequencer.md
# battle_sequencer

Parametrised turn and round controller for the battle screen. It steps through `NUM_PHASES` game phases in order (menu, player, enemy, …), advancing on each phase's finish edge or on a watchdog timeout, and issues a one-cycle round-reset pulse at the end of every round. It also tracks player and enemy HP, declares WIN or LOSE, and composites the active phase's pixel with the shared overlay (health bar, enemy sprite) using per-channel saturating addition. It sits directly under the top level and replaces the fixed three-state sequencer.

## Interface
Parameters:
- `NUM_PHASES`, 3: number of phases per round (≥2); phase 0 is entered first.
- `HP_W`, 8: width of HP counters.
- `PLAYER_MAX_HP`, 20: player HP after reset or restart.
- `ENEMY_MAX_HP`, 100: enemy HP after reset or restart.
- `MAX_ROUNDS`, 0: rounds survived that force WIN; 0 means unlimited.
- `TIMEOUT_CYCLES`, 0: watchdog cycles per phase before forced advance; 0 disables the watchdog.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset. The block is in reset while `rst`=0 on a `clk` edge.
- `finished_in` in NUM_PHASES: level finish flag per phase.
- `damage_in` in 1: one-cycle pulse; player loses 1 HP.
- `attack_valid_in` in 1: one-cycle pulse; enemy loses `attack_amt_in`.
- `attack_amt_in` in HP_W: damage amount, sampled with `attack_valid_in`.
- `restart_in` in 1: one-cycle pulse; leaves WIN/LOSE.
- `phase_pixel_in` in 12·NUM_PHASES: phase k pixel at bits [12k+11:12k], 4:4:4 RGB.
- `overlay_pixel_in` in 12: overlay pixel (0 where transparent).
- `phase_onehot_out` out NUM_PHASES: active phase (one-hot); all-zero in WIN/LOSE.
- `phase_idx_out` out $clog2(NUM_PHASES): active phase index.
- `round_rst_out` out 1: one-cycle pulse at round end. Drives phase-module resets.
- `round_count_out` out 16: completed rounds, saturating at 16'hFFFF.
- `player_hp_out`, `enemy_hp_out` out HP_W: current HP.
- `win_out`, `lose_out` out 1: terminal status levels.
- `pixel_out` out 12: composited pixel.

## Operation
- States: PHASE(k), ROUND_END, WIN, LOSE.
- Reset (`rst`=0) sets:
  - state to PHASE(0), `phase_onehot_out`=1, `phase_idx_out`=0;
  - `round_rst_out`=0, `round_count_out`=0;
  - HP to their MAX values;
  - `win_out`=`lose_out`=0, `pixel_out`=0, watchdog=0;
  - all finish edge detectors to 0.
- Finish edge detection: the block keeps a registered copy of `finished_in`. A rising edge on bit k (0→1) counts only while the state is PHASE(k); rising edges on other bits are ignored.
- PHASE(k) with k<NUM_PHASES-1: a finish edge or watchdog expiry moves to PHASE(k+1).
- PHASE(NUM_PHASES-1): a finish edge or watchdog expiry moves to ROUND_END.
- ROUND_END lasts exactly one cycle:
  - `round_rst_out`=1 and `round_count_out` increments.
  - Next state is PHASE(0).
  - If the incremented count equals MAX_ROUNDS (and MAX_ROUNDS≠0), next state is WIN instead.
- Watchdog: clears on every phase entry and increments each cycle in PHASE. Expiry is reaching TIMEOUT_CYCLES-1, so a phase lasts at most TIMEOUT_CYCLES cycles.
- HP arithmetic:
  - player_hp = player_hp − 1, saturating at 0.
  - enemy_hp = enemy_hp − attack_amt, saturating at 0.
  - HP updates are accepted in any PHASE state and in ROUND_END, and ignored in WIN/LOSE.
- Terminal checks use the next-cycle HP values:
  - player HP reaching 0 → LOSE;
  - enemy HP reaching 0 → WIN.
- Terminal priority, highest first: LOSE > WIN > phase advance. On the same cycle, death overrides both a finish edge and a ROUND_END transition.
- WIN/LOSE:
  - Phase outputs go to zero and the finish and watchdog inputs are ignored.
  - `restart_in` restores both HP values, clears `round_count_out`, and enters PHASE(0) with a one-cycle `round_rst_out` pulse.
  - `restart_in` outside WIN/LOSE is ignored.
- Pixel: `pixel_out` per R/G/B nibble = min(15, active phase nibble + overlay nibble). In WIN/LOSE, `pixel_out` = overlay only.

## Timing
- All outputs are registered.
- A finish edge sampled on edge N shows its new phase on edge N+1. The edge detector adds one cycle, so `finished_in` rising before edge N-1 produces the new phase at N+1, i.e. 2 cycles from input to phase change.
- Round end to next round: `round_rst_out` is high for the single cycle after the last phase finishes; PHASE(0) is active on the following cycle.
- `damage_in` or `attack_valid_in` at edge N: the HP output updates at N+1, and the terminal state shows at N+1.
- Pixel latency is exactly 1 cycle from `phase_pixel_in`/`overlay_pixel_in` to `pixel_out`. Callers delay hcount/vcount-dependent data by 1 cycle.
- Reset applied mid-phase or during ROUND_END takes effect at the next edge. No `round_rst_out` pulse is generated by reset.

## Test plan
- NUM_PHASES=3, no timeout, pulse `finished_in` bits 0,1,2 in turn. Required: phase_idx goes 0→1→2; one `round_rst_out` pulse; round_count=1; phase_idx=0 one cycle after the pulse.
- Out-of-phase finish: in PHASE(0), raise `finished_in[2]`. Required: no transition. Hold `finished_in[0]` high for 10 cycles. Required: exactly one advance.
- TIMEOUT_CYCLES=8, no finish inputs. Required: each phase lasts 8 cycles and a round completes in 24 cycles plus 1 ROUND_END cycle.
- Player HP and death priority:
  - PLAYER_MAX_HP=2: send two `damage_in` pulses, the second on the same cycle as the last phase's finish edge. Required: player_hp=0, `lose_out`=1, no `round_rst_out`, round_count unchanged.
  - A third `damage_in` leaves HP at 0.
- Enemy HP saturation: ENEMY_MAX_HP=100, attack amounts 60 then 60. Required: enemy_hp 40, then 0, with `win_out`=1. `restart_in` then gives HP 20/100, round_count=0, a `round_rst_out` pulse, and PHASE(0).
- Pixel compositing: active phase pixel 12'hA5F with overlay 12'h7A3. Required: `pixel_out`=12'hFFF one cycle later. In LOSE with overlay 12'h123, `pixel_out`=12'h123.
